// File: rtl/narrow_pkg.sv
// Shared definitions for the 16-to-4 signed narrowing stage: default widths,
// 4-bit saturation limits and the stored entry type {data, fits}.
package narrow_pkg;

    localparam int unsigned IN_W_DEF  = 16;
    localparam int unsigned OUT_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    localparam logic [3:0] SAT_MAX_4 = 4'b0111;
    localparam logic [3:0] SAT_MIN_4 = 4'b1000;

    typedef struct packed {
        logic [OUT_W_DEF-1:0] data;
        logic                 fits;
    } narrow_entry_t;

endpackage

// File: rtl/narrow_16to4_stage_if.sv
// Handshake/data bundle for narrow_16to4_stage. The master side is the
// producer/consumer environment; the slave side is the stage itself.
interface narrow_16to4_stage_if
    import narrow_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic [IN_W-1:0]  Din16;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] Dout4;
    logic             fits;
    logic             out_valid;
    logic             out_ready;
    logic             cnt_clr;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output Din16, in_valid, out_ready, cnt_clr,
        input  in_ready, Dout4, fits, out_valid, ovf_count
    );

    modport slave (
        input  Din16, in_valid, out_ready, cnt_clr,
        output in_ready, Dout4, fits, out_valid, ovf_count
    );
endinterface

// File: rtl/narrow_skid_buf.sv
// Generic two-entry valid/ready skid buffer: an output register (OR) feeding
// the consumer plus a skid register (SK) that absorbs one word when OR stalls.
// in_ready is registered and equals "SK empty after this edge".
module narrow_skid_buf
    import narrow_pkg::*;
#(
    parameter type T = narrow_entry_t
) (
    input  logic clk,
    input  logic reset_n,
    input  T     in_data_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    output T     out_data_o,
    output logic out_valid_o,
    input  logic out_ready_i
);
    T     or_q, or_d;
    T     sk_q, sk_d;
    logic or_v_q, or_v_d;
    logic sk_v_q, sk_v_d;
    logic rdy_q, rdy_d;
    logic push, pop;

    // Next-state for OR/SK occupancy; SK always drains into OR first to keep order.
    always_comb begin
        or_d   = or_q;
        sk_d   = sk_q;
        or_v_d = or_v_q;
        sk_v_d = sk_v_q;
        push   = in_valid_i && rdy_q;
        pop    = or_v_q && out_ready_i;

        if (pop) begin
            if (sk_v_q) begin
                or_d   = sk_q;
                sk_v_d = push;
                if (push) begin
                    sk_d = in_data_i;
                end
            end else if (push) begin
                or_d = in_data_i;
            end else begin
                or_v_d = 1'b0;
            end
        end else if (push) begin
            if (or_v_q) begin
                sk_d   = in_data_i;
                sk_v_d = 1'b1;
            end else begin
                or_d   = in_data_i;
                or_v_d = 1'b1;
            end
        end

        rdy_d = !sk_v_d;
    end

    // Storage registers; reset empties both entries and reopens the input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            or_q   <= '0;
            sk_q   <= '0;
            or_v_q <= 1'b0;
            sk_v_q <= 1'b0;
            rdy_q  <= 1'b1;
        end else begin
            or_q   <= or_d;
            sk_q   <= sk_d;
            or_v_q <= or_v_d;
            sk_v_q <= sk_v_d;
            rdy_q  <= rdy_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_data_o  = or_q;
    assign out_valid_o = or_v_q;
endmodule

// File: rtl/narrow_16to4_stage.sv
// Pipelined signed narrowing stage: IN_W-bit signed words in, OUT_W-bit signed
// fields out with a fits flag, through a two-entry skid buffer. Counts accepted
// words that do not fit (saturating, clearable).
// Optional build macro SATURATE_EN: non-fitting words clamp to the most
// negative/positive OUT_W value instead of truncating.
module narrow_16to4_stage
    import narrow_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input logic                  clk,
    input logic                  reset_n,
    narrow_16to4_stage_if.slave  bus
);
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             fits;
    } stage_entry_t;

    stage_entry_t     in_entry;
    stage_entry_t     out_entry;
    logic [IN_W-OUT_W:0] upper;
    logic             fit;
    logic             accept;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fit test and narrowing, evaluated on the incoming word at acceptance.
    always_comb begin
        upper         = bus.Din16[IN_W-1:OUT_W-1];
        fit           = (&upper) || !(|upper);
        in_entry.fits = fit;
`ifdef SATURATE_EN
        if (fit) begin
            in_entry.data = bus.Din16[OUT_W-1:0];
        end else if (bus.Din16[IN_W-1]) begin
            in_entry.data = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            in_entry.data = {1'b0, {(OUT_W-1){1'b1}}};
        end
`else
        in_entry.data = bus.Din16[OUT_W-1:0];
`endif
    end

    narrow_skid_buf #(
        .T (stage_entry_t)
    ) u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data_i   (in_entry),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .out_data_o  (out_entry),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready)
    );

    assign accept = bus.in_valid && bus.in_ready;

    // Overflow counter next value: clear wins over increment, saturate at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (accept && !fit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Overflow counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.Dout4     = out_entry.data;
    assign bus.fits      = out_entry.fits;
    assign bus.ovf_count = cnt_q;
endmodule

// File: tb/tb_narrow_16to4_stage.sv
// Self-checking bench for narrow_16to4_stage: directed steps from the test plan
// followed by randomized traffic, checked against a queue-based reference.
module tb_narrow_16to4_stage;
    import narrow_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    typedef struct {
        logic [3:0] d;
        logic       f;
    } ent_t;

    ent_t q[$];
    int   cnt_model;

    narrow_16to4_stage_if #(.IN_W(16), .OUT_W(4), .CNT_W(8)) bus ();

    narrow_16to4_stage #(.IN_W(16), .OUT_W(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference narrowing: signed range test with plain integer arithmetic.
    function automatic ent_t narrow(input logic [15:0] w);
        ent_t e;
        int   v;
        v   = int'($signed(w));
        e.f = (v >= -8) && (v <= 7);
        if (e.f) begin
            e.d = w[3:0];
        end else begin
`ifdef SATURATE_EN
            e.d = (v < 0) ? SAT_MIN_4 : SAT_MAX_4;
`else
            e.d = w[3:0];
`endif
        end
        return e;
    endfunction

    // One clock: check visible outputs against the model, advance, check counter.
    task automatic cyc();
        bit   acc;
        bit   pop;
        bit   clr;
        ent_t e;
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("Dout4", 32'(bus.Dout4), 32'(q[0].d));
            chk("fits", 32'(bus.fits), 32'(q[0].f));
        end
        acc = bus.in_valid && (q.size() < 2);
        pop = (q.size() > 0) && bus.out_ready;
        clr = bus.cnt_clr;
        e   = narrow(bus.Din16);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (clr) cnt_model = 0;
        else if (acc && !e.f && cnt_model < 255) cnt_model++;
        #1;
        chk("ovf_count", 32'(bus.ovf_count), 32'(cnt_model));
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        int          v;
        case ($urandom_range(0, 3))
            0: begin v = int'($urandom_range(0, 32)) - 16; w = v[15:0]; end
            1: begin
                case ($urandom_range(0, 3))
                    0: w = 16'h0007;
                    1: w = 16'h0008;
                    2: w = 16'hFFF8;
                    default: w = 16'hFFF7;
                endcase
            end
            default: w = 16'($urandom);
        endcase
        return w;
    endfunction

    initial begin
        checks         = 0;
        failures       = 0;
        cnt_model      = 0;
        reset_n        = 1'b0;
        bus.Din16      = '0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.cnt_clr    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_Dout4", 32'(bus.Dout4), 32'd0);
        chk("rst_fits", 32'(bus.fits), 32'd0);
        chk("rst_ovf", 32'(bus.ovf_count), 32'd0);
        reset_n = 1'b1;

        // Simple fitting word, 1-cycle latency
        bus.out_ready = 1'b1;
        bus.Din16     = 16'h0005;
        bus.in_valid  = 1'b1;
        cyc();
        bus.in_valid  = 1'b0;
        chk("t1_Dout4", 32'(bus.Dout4), 32'h5);
        chk("t1_fits", 32'(bus.fits), 32'd1);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_ovf", 32'(bus.ovf_count), 32'd0);
        cyc();

        // -8 fits, +8 does not
        bus.Din16    = 16'hFFF8;
        bus.in_valid = 1'b1;
        cyc();
        chk("m8_Dout4", 32'(bus.Dout4), 32'h8);
        chk("m8_fits", 32'(bus.fits), 32'd1);
        bus.Din16 = 16'h0008;
        cyc();
`ifdef SATURATE_EN
        chk("p8_Dout4", 32'(bus.Dout4), 32'h7);
`else
        chk("p8_Dout4", 32'(bus.Dout4), 32'h8);
`endif
        chk("p8_fits", 32'(bus.fits), 32'd0);
        chk("p8_ovf", 32'(bus.ovf_count), 32'd1);

        // Most negative word
        bus.Din16 = 16'h8000;
        cyc();
        bus.in_valid = 1'b0;
`ifdef SATURATE_EN
        chk("min_Dout4", 32'(bus.Dout4), 32'h8);
`else
        chk("min_Dout4", 32'(bus.Dout4), 32'h0);
`endif
        chk("min_fits", 32'(bus.fits), 32'd0);
        chk("min_ovf", 32'(bus.ovf_count), 32'd2);
        cyc();

        // Stall: 1 in OR, 2 in SK, 3 refused; then drain in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.Din16     = 16'h0001;
        cyc();
        bus.Din16 = 16'h0002;
        cyc();
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_hold", 32'(bus.Dout4), 32'h1);
        bus.Din16 = 16'h0003;
        cyc();
        chk("stall_hold2", 32'(bus.Dout4), 32'h1);
        bus.out_ready = 1'b1;
        cyc();
        chk("unstall_Dout4", 32'(bus.Dout4), 32'h2);
        chk("unstall_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        chk("unstall_Dout4_3", 32'(bus.Dout4), 32'h3);
        cyc();
        cyc();

        // Counter saturation then clear on a same-cycle non-fit accept
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.Din16 = 16'h0100 | 16'($urandom_range(0, 16'h7E00));
            cyc();
        end
        chk("sat_ovf", 32'(bus.ovf_count), 32'd255);
        bus.Din16   = 16'hF000;
        bus.cnt_clr = 1'b1;
        cyc();
        bus.cnt_clr = 1'b0;
        chk("clr_ovf", 32'(bus.ovf_count), 32'd0);
        bus.in_valid = 1'b0;
        cyc();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.Din16     = rand_word();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.cnt_clr   = ($urandom_range(0, 49) == 0);
            cyc();
        end
        bus.cnt_clr = 1'b0;

        // Reset asserted mid-stall with both entries full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.Din16 = rand_word();
            cyc();
        end
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_ovf", 32'(bus.ovf_count), 32'd0);
        q.delete();
        cnt_model    = 0;
        bus.in_valid = 1'b0;
        #1;
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
        end
        bus.Din16    = 16'hFFFF;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        chk("post_rst_Dout4", 32'(bus.Dout4), 32'hF);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
